// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 8-digit multiplexed seven-segment scan controller.
package display_scan_ctrl_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam logic [7:0]  SEG_BLANK  = 8'hFF;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DEAD  = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_decode.sv
// Hex nibble to active-low seven-segment pattern; SEG[7] (dp) is always off here.
module decode_show
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_nib)
         4'h0: o_seg = 8'hC0;
         4'h1: o_seg = 8'hF9;
         4'h2: o_seg = 8'hA4;
         4'h3: o_seg = 8'hB0;
         4'h4: o_seg = 8'h99;
         4'h5: o_seg = 8'h92;
         4'h6: o_seg = 8'h82;
         4'h7: o_seg = 8'hF8;
         4'h8: o_seg = 8'h80;
         4'h9: o_seg = 8'h98;
         4'hA: o_seg = 8'h88;
         4'hB: o_seg = 8'h83;
         4'hC: o_seg = 8'hC6;
         4'hD: o_seg = 8'hA1;
         4'hE: o_seg = 8'h86;
         4'hF: o_seg = 8'h8E;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit display scanner: blank slot between digits, shadow data committed only at frame end.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned DIV         = 100000,
   parameter bit          LZ_SUPPRESS = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] din,
   input  logic [7:0]  dp_in,
   output logic [7:0]  AN,
   output logic [7:0]  SEG,
   output logic        upd_done
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   scan_state_t   r_state, w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [31:0]   r_shadow_val, r_active_val;
   logic [7:0]    r_shadow_dp, r_active_dp;
   logic          r_pending, r_upd_done;
   logic [7:0]    r_an, r_seg;
   logic          w_tick, w_slot_end, w_commit, w_zero_run;
   logic [3:0]    w_nib;
   logic [7:0]    w_dec, w_lz_mask, w_an_nx, w_seg_nx;

   assign w_tick     = (r_state == ST_DRIVE) && (r_cnt == CW'(DIV - 1));
   assign w_slot_end = en && w_tick;
   assign w_commit   = w_slot_end && (r_idx == 3'd7) && r_pending;
   assign w_nib      = r_active_val[{r_idx, 2'b00} +: 4];

   decode_show u_decode (
      .i_nib (w_nib),
      .o_seg (w_dec)
   );

   always_comb begin
      w_state_nx = r_state;
      if (!en) begin
         w_state_nx = ST_OFF;
      end else begin
         case (r_state)
            ST_OFF:   w_state_nx = ST_DEAD;
            ST_DEAD:  w_state_nx = ST_DRIVE;
            ST_DRIVE: if (w_tick) w_state_nx = ST_DEAD;
            default:  w_state_nx = ST_OFF;
         endcase
      end
   end

   // A digit is a leading zero when it and every higher digit are zero with no dp lit.
   always_comb begin
      w_lz_mask  = '0;
      w_zero_run = 1'b1;
      for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
         w_zero_run   = w_zero_run && (r_active_val[4*k +: 4] == 4'h0) && !r_active_dp[k];
         w_lz_mask[k] = w_zero_run;
      end
   end

   always_comb begin
      w_an_nx  = SEG_BLANK;
      w_seg_nx = SEG_BLANK;
      if (en && (r_state == ST_DRIVE)) begin
         w_an_nx = ~(8'b1 << r_idx);
         if (LZ_SUPPRESS && w_lz_mask[r_idx]) w_an_nx = SEG_BLANK;
         w_seg_nx = {w_dec[7] & ~r_active_dp[r_idx], w_dec[6:0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         if (!en) begin
            r_cnt <= '0;
            r_idx <= '0;
         end else begin
            if (r_state == ST_DRIVE) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_slot_end)          r_idx <= r_idx + 3'd1;
         end
      end
   end

   // On a load/commit collision the commit takes the pre-load shadow and pending stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_val <= '0;
         r_shadow_dp  <= '0;
         r_active_val <= '0;
         r_active_dp  <= '0;
         r_pending    <= 1'b0;
         r_upd_done   <= 1'b0;
      end else begin
         if (w_commit) begin
            r_active_val <= r_shadow_val;
            r_active_dp  <= r_shadow_dp;
         end
         if (load) begin
            r_shadow_val <= din;
            r_shadow_dp  <= dp_in;
         end
         if (load)          r_pending <= 1'b1;
         else if (w_commit) r_pending <= 1'b0;
         r_upd_done <= w_commit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= SEG_BLANK;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= w_an_nx;
         r_seg <= w_seg_nx;
      end
   end

   assign AN       = r_an;
   assign SEG      = r_seg;
   assign upd_done = r_upd_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (DIV=4) with a frame-position reference model.
module tb_display_scan_ctrl;

   localparam int DIV   = 4;
   localparam int SLOT  = DIV + 1;
   localparam int FRAME = 8 * SLOT;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [31:0] din;
   logic [7:0]  dp_in;
   logic [7:0]  an0, seg0, an1, seg1;
   logic        upd0, upd1;

   always #5 clk = ~clk;

   display_scan_ctrl #(.DIV(DIV), .LZ_SUPPRESS(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
      .AN(an0), .SEG(seg0), .upd_done(upd0)
   );

   display_scan_ctrl #(.DIV(DIV), .LZ_SUPPRESS(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp_in(dp_in),
      .AN(an1), .SEG(seg1), .upd_done(upd1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int n_upd0 = 0;
   logic [7:0] lit0 = 8'h00;
   logic [7:0] lit1 = 8'h00;
   bit chk_on = 1'b0;

   logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model: m_pos is the position in the 40-cycle frame (-1 = off); slot offset 0 is the blank.
   int          m_pos;
   logic [31:0] m_shv, m_act;
   logic [7:0]  m_shdp, m_adp;
   bit          m_pend;
   logic [7:0]  e_an [2];
   logic [7:0]  e_seg;
   bit          e_upd;

   always @(posedge clk or posedge rst) begin : model
      int d;
      bit commit;
      if (rst) begin
         m_pos = -1; m_shv = '0; m_act = '0; m_shdp = '0; m_adp = '0; m_pend = 1'b0;
         e_an[0] = 8'hFF; e_an[1] = 8'hFF; e_seg = 8'hFF; e_upd = 1'b0;
      end else begin
         commit  = en && (m_pos == FRAME - 1) && m_pend;
         e_an[0] = 8'hFF; e_an[1] = 8'hFF; e_seg = 8'hFF;
         if (en && m_pos >= 0 && (m_pos % SLOT) != 0) begin
            d       = m_pos / SLOT;
            e_an[0] = ~(8'h01 << d);
            e_an[1] = (d > 0 && (m_act >> (4*d)) == 0 && (m_adp >> d) == 0) ? 8'hFF : e_an[0];
            e_seg   = {~m_adp[d], hex_tab[(m_act >> (4*d)) & 32'hF][6:0]};
         end
         e_upd = commit;
         if (commit) begin m_act = m_shv; m_adp = m_shdp; m_pend = 1'b0; end
         if (load)   begin m_shv = din;   m_shdp = dp_in; m_pend = 1'b1; end
         m_pos = en ? (m_pos + 1) % FRAME : -1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_an",     an0,  e_an[0]);
         check("cyc_an_lz",  an1,  e_an[1]);
         check("cyc_seg",    seg0, e_seg);
         check("cyc_seg_lz", seg1, e_seg);
         check("cyc_upd",    32'(upd0), 32'(e_upd));
         check("cyc_upd_lz", 32'(upd1), 32'(e_upd));
      end
      if (upd0) n_upd0++;
      lit0 = lit0 | ~an0;
      lit1 = lit1 | ~an1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic goto_pos(input int t);
      for (int i = 0; i < 200 && m_pos != t; i++) step(1);
      if (m_pos != t) begin
         n_cmp++; n_bad++;
         $display("FAIL goto_pos: got %0d expected %0d", m_pos, t);
      end
   endtask

   task automatic wait_upd(input string name);
      for (int i = 0; i < 200 && !upd0; i++) step(1);
      check(name, 32'(upd0), 32'd1);
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] dp);
      load = 1'b1; din = v; dp_in = dp;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; din = '0; dp_in = '0;
      step(3);
      check("rst_an",  an0, 8'hFF);
      check("rst_seg", seg0, 8'hFF);
      check("rst_upd", 32'(upd0), 32'd0);
      chk_on = 1'b1;
      rst = 1'b0;
      step(2);
      check("off_an", an0, 8'hFF);
      en = 1'b1;
      step(3);
      check("up_an",  an0, 8'hFE);
      check("up_seg", seg0, 8'hC0);

      // scan of 89ABCDEF
      do_load(32'h89ABCDEF, 8'h00);
      n_upd0 = 0;
      wait_upd("scan_upd");
      step(2);
      check("scan_d0_an", an0, 8'hFE);  check("scan_d0_seg", seg0, 8'h8E);
      step(15);
      check("scan_d3_an", an0, 8'hF7);  check("scan_d3_seg", seg0, 8'hC6);
      step(20);
      check("scan_d7_an", an0, 8'h7F);  check("scan_d7_seg", seg0, 8'h80);
      step(FRAME);
      check("scan_upd_once", n_upd0, 1);

      // tear-free: loads at idx 3 and idx 5
      n_upd0 = 0;
      goto_pos(17);
      do_load(32'h12345678, 8'h00);
      goto_pos(27);
      do_load(32'h76543210, 8'h01);
      wait_upd("tear_upd");
      step(2);
      check("tear_d0_seg", seg0, 8'h40);
      step(35);
      check("tear_d7_seg", seg0, 8'hF8);
      step(FRAME);
      check("tear_upd_once", n_upd0, 1);

      // load collides with commit
      goto_pos(20);
      do_load(32'h0000000A, 8'h00);
      goto_pos(FRAME - 1);
      n_upd0 = 0;
      do_load(32'h0000000B, 8'h00);
      check("coll_upd1", 32'(upd0), 32'd1);
      step(2);
      check("coll_old", seg0, 8'h88);
      wait_upd("coll_upd2");
      step(2);
      check("coll_new", seg0, 8'h83);
      check("coll_two_pulses", n_upd0, 2);

      // en low at idx 4, load while off, restart
      goto_pos(20);
      en = 1'b0;
      step(1);
      check("en_low_an", an0, 8'hFF);
      do_load(32'h00000120, 8'h00);
      n_upd0 = 0;
      step(3);
      check("off_no_upd", n_upd0, 0);
      en = 1'b1;
      step(3);
      check("en_restart_an",  an0, 8'hFE);
      check("en_restart_seg", seg0, 8'h83);
      wait_upd("off_load_upd");

      // leading-zero suppression of 00000120
      lit0 = 8'h00; lit1 = 8'h00;
      step(FRAME);
      check("lz_lit_mask",   lit1, 8'h07);
      check("nolz_lit_mask", lit0, 8'hFF);

      // reset mid-frame with pending data
      do_load(32'hFFFFFFFF, 8'hFF);
      goto_pos(12);
      rst = 1'b1;
      #1;
      check("midrst_an",  an0, 8'hFF);
      check("midrst_seg", seg0, 8'hFF);
      check("midrst_upd", 32'(upd0), 32'd0);
      check("midrst_an_lz", an1, 8'hFF);
      n_upd0 = 0;
      step(2);
      rst = 1'b0;
      step(3);
      check("rst_restart_an",  an0, 8'hFE);
      check("rst_restart_seg", seg0, 8'hC0);
      step(2 * FRAME);
      check("rst_no_commit", n_upd0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000, meaning clk cycles per digit slot (legal range 2 to 2^20).
REQ-002 SHALL have parameter LZ_SUPPRESS, default 0, where 1 blanks leading zero digits.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, where 1 enables scanning and 0 darkens the display.
REQ-006 SHALL have port load, input, 1 bit, a one-cycle write strobe for din and dp_in.
REQ-007 SHALL have port din, input, 32 bits, eight hex nibbles, with digit k = din[4k+3:4k].
REQ-008 SHALL have port dp_in, input, 8 bits, the decimal-point request per digit (1 = lit).
REQ-009 SHALL have port AN, output, 8 bits, the active-low digit enables, with AN[k] for digit k.
REQ-010 SHALL have port SEG, output, 8 bits, the active-low segments, with SEG[7] = dp and SEG[6:0] = g..a.
REQ-011 SHALL have port upd_done, output, 1 bit, a one-cycle pulse when shadow data is committed to display.

Function
REQ-012 SHALL register load data into shadow registers (shadow_val, shadow_dp) and set flag pending on every cycle with load=1; the latest load SHALL win.
REQ-013 SHALL contain a prescaler counting 0..DIV-1 while in DRIVE, where tick = (count==DIV-1) and count returns to 0 after tick.
REQ-014 SHALL implement FSM states OFF, DEAD and DRIVE.
REQ-015 SHALL transition OFF->DEAD when en=1, DEAD->DRIVE unconditionally after 1 cycle, and DRIVE->DEAD on tick.
REQ-016 SHALL transition any state->OFF when en=0, clearing the prescaler and digit index to 0.
REQ-017 SHALL hold 3-bit digit index idx, incrementing on each DRIVE->DEAD transition and wrapping 7->0.
REQ-018 SHALL commit to the active registers on the DRIVE->DEAD transition with idx==7 and pending=1: active<=shadow, pending<=0, upd_done=1 next cycle; this makes commits tear-free at frame boundaries only.
REQ-019 SHALL, when load coincides with a commit, commit the pre-load shadow and leave pending=1 so the new data commits at the next frame end.
REQ-020 SHALL, while in OFF, still accept loads; no commit occurs in OFF.
REQ-021 SHALL drive AN=8'hFF and SEG=8'hFF in OFF and DEAD (anti-ghosting blank slot).
REQ-022 SHALL, in DRIVE, drive AN = ~(1<<idx) and SEG[6:0] = hex code of active nibble idx, with SEG[7] = ~active_dp[idx].
REQ-023 SHALL use hex codes (SEG[7:0] with dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=98 A=88 B=83 C=C6 D=A1 E=86 F=8E.
REQ-024 SHALL register AN and SEG outputs, so they reflect the state/idx of the previous cycle (1-cycle latency).
REQ-025 SHALL, when LZ_SUPPRESS=1, blank digit k (AN[k]=1) in DRIVE if all nibbles k..7 are 0, k>0, and active_dp[k..7]=0; digit 0 SHALL never be suppressed.
REQ-026 SHALL make upd_done exactly one cycle wide and never assert outside a commit.

Reset
REQ-027 SHALL, on rst=1, asynchronously set: state=OFF, idx=0, prescaler=0, active and shadow values=0, dp registers=0, pending=0, upd_done=0, AN=8'hFF, SEG=8'hFF.
REQ-028 SHALL, on reset mid-frame, discard pending data without a commit pulse.
REQ-029 SHALL, on reset release, sample the first transition at the next clk edge.

Structure
REQ-030 SHALL place the FSM state encoding, digit count (8) and the blank code 8'hFF in a shared display package.
REQ-031 SHALL instantiate one combinational sub-module, the team hex-to-segment decoder decode_show (4-bit in, 8-bit active-low out), fed by the selected nibble, with dp overlaid on SEG[7].

Verification (DIV=4)
REQ-032 SHALL verify reset: assert rst mid-DRIVE -> AN=FF, SEG=FF, upd_done=0 immediately; release with en=1 -> DEAD then DRIVE, AN=FE, SEG=C0.
REQ-033 SHALL verify scan: load din=32'h89ABCDEF, dp_in=0 -> after frame end upd_done pulses once; digit 0 SEG=8E, digit 3 SEG=C6, digit 7 SEG=80; AN steps FE,FD..7F, with one FF cycle between digits; 5 cycles per slot.
REQ-034 SHALL verify tear-free update: loads at idx=3 and idx=5 -> display unchanged until idx 7->0, then shows the idx=5 value; a single upd_done pulse.
REQ-035 SHALL verify collision: load on the commit cycle -> the old shadow is committed and a second upd_done occurs one frame later with the new value.
REQ-036 SHALL verify en low: drop en at idx=4 -> AN=FF next cycle; raise en -> restart at idx=0.
REQ-037 SHALL verify LZ_SUPPRESS=1: din=32'h00000120, dp_in=0 -> only digits 0..2 lit; digits 3..7 AN bits stay 1.
